alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 id_valid  input  1  decode-stage instruction present.
REQ-005 id_instr  input  32  RV32I instruction word.
REQ-006 id_pc  input  32  instruction PC, word index (byte address / 4).
REQ-007 rs1_data, rs2_data  input  32 each  register-file read data.
REQ-008 ex_stall  input  1  execute stage cannot accept; hold ID/EX register.
REQ-009 ex_branch_taken  input  1  branch_taken from the ALU; flush request.
REQ-010 id_ready  output  1  this cycle's decode instruction is consumed.
REQ-011 ex_valid  output  1  ID/EX register holds a real instruction.
REQ-012 ex_ctrl  output  4  ALU control code; ex_in1, ex_in2, ex_pc  output  32 each  ALU operands and PC.
REQ-013 ex_rd  output  5; ex_we, ex_is_branch, ex_is_load, ex_is_store, ex_illegal  output  1 each.

Function
REQ-014 ALU codes SHALL be: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, BEQ 7, BNE 8, SLT 9, SRA A, AUIPC B, BLT C, BGE D.
REQ-015 R-type: add/sub/xor/or/and/sll/srl/sra/slt/sltu SHALL map to 0/1/2/3/4/5/6/A/9/9; in1=rs1_data, in2=rs2_data, we=1.
REQ-016 I-type ALU: addi/xori/ori/andi/slti/sltiu SHALL map to 0/2/3/4/9/9, in2 = sign-extended imm[11:0]; slli/srli/srai map to 5/6/A, in2 = zero-extended shamt[4:0].
REQ-017 Branches: beq/bne/blt/bltu/bge/bgeu SHALL map to 7/8/C/C/D/D, in1=rs1_data, in2=rs2_data, is_branch=1, we=0, rd=0.
REQ-018 Loads/stores SHALL use ctrl 0, in1=rs1_data, in2 = sign-extended I/S immediate; load sets is_load, we=1; store sets is_store, we=0, rd=0.
REQ-019 LUI SHALL use ctrl 0, in1=0, in2=instr[31:12]<<12, we=1.
REQ-020 AUIPC SHALL use ctrl B, in1=0, in2 = zero-extended instr[31:12] (unshifted), ex_pc=id_pc, we=1.
REQ-021 Any other opcode/funct (incl. JAL, JALR, SYSTEM) SHALL issue with ex_valid=1, ex_illegal=1, ctrl 0, we=0, all flags 0.
REQ-022 Load-use hazard: when ex_valid & ex_is_load & ex_rd!=0 and ex_rd equals a source register the decoded instruction reads, the block SHALL drive id_ready=0 and load a bubble (ex_valid=0) at the next edge.
REQ-023 Hazard SHALL insert exactly one bubble; the following cycle the instruction issues normally.
REQ-024 id_ready SHALL equal (!ex_stall & !hazard) | ex_branch_taken, combinationally.
REQ-025 With ex_stall=1 and ex_branch_taken=0 all ex_* registers SHALL hold.
REQ-026 With ex_branch_taken=1 the block SHALL clear ex_valid at the next edge regardless of ex_stall or hazard, and discard the consumed decode instruction.
REQ-027 Otherwise, with id_valid=0 the next edge SHALL load a bubble; with id_valid=1 and id_ready=1 it SHALL load the decoded instruction.
REQ-028 A bubble SHALL have ex_valid=0, ex_we=0 and all flags 0; operand fields are don't-care.
REQ-029 Latency: decode to ex_* outputs SHALL be one cycle.

Reset
REQ-030 When rst=1 at an edge, ex_valid, ex_we, ex_is_branch, ex_is_load, ex_is_store and ex_illegal SHALL be 0, and ex_ctrl, ex_in1, ex_in2, ex_pc and ex_rd SHALL be 0.
REQ-031 rst SHALL take priority over flush, stall and hazard; an instruction in flight is dropped.

Structure
REQ-032 ALU code constants and RV32I opcode/funct constants SHALL live in a shared package used by this block and the ALU.
REQ-033 Decode SHALL be a combinational sub-module alu_decode; alu_issue holds hazard, handshake and register logic.

Verification
REQ-034 addi x1,x2,-5 (rs1_data=10) -> next cycle ex_ctrl=0, ex_in1=10, ex_in2=0xFFFFFFFB, ex_rd=1, ex_we=1.
REQ-035 lw x3,0(x4), then add x5,x3,x6 -> id_ready=0 one cycle, one bubble (ex_valid=0), then add issues with ex_ctrl=0.
REQ-036 ex_stall=1 for 3 cycles with sub pending -> ex_* unchanged for 3 cycles, id_ready=0.
REQ-037 ex_branch_taken=1 with ex_stall=1 -> ex_valid=0 next cycle, id_ready=1 that cycle.
REQ-038 auipc x7,0x12345 at id_pc=0x100 -> ex_ctrl=B, ex_in1=0, ex_in2=0x00012345, ex_pc=0x100.
REQ-039 rst=1 asserted mid-stream -> all ex_* 0 at next edge; opcode 0x7F -> ex_illegal=1, ex_we=0.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: ALU codes, RV32I opcode/funct constants and the ID/EX register layout
package alu_issue_pkg;
  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_XOR   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_AND   = 4'h4,
    ALU_SLL   = 4'h5,
    ALU_SRL   = 4'h6,
    ALU_BEQ   = 4'h7,
    ALU_BNE   = 4'h8,
    ALU_SLT   = 4'h9,
    ALU_SRA   = 4'hA,
    ALU_AUIPC = 4'hB,
    ALU_BLT   = 4'hC,
    ALU_BGE   = 4'hD
  } alu_op_e;
  localparam logic [6:0] OP_R     = 7'h33;
  localparam logic [6:0] OP_IMM   = 7'h13;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] F7_BASE  = 7'h00;
  localparam logic [6:0] F7_ALT   = 7'h20;
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;
  typedef struct packed {
    logic        valid;
    logic [3:0]  ctrl;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        is_branch;
    logic        is_load;
    logic        is_store;
    logic        illegal;
  } ex_reg_t;
  function automatic logic [31:0] sext12(input logic [11:0] imm);
    return {{20{imm[11]}}, imm};
  endfunction
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational RV32I decode into ALU control, operands and source-register usage
module alu_decode
  import alu_issue_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic [3:0]  o_ctrl,
  output logic [31:0] o_in1,
  output logic [31:0] o_in2,
  output logic [4:0]  o_rd,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic        o_we,
  output logic        o_is_branch,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_illegal
);
  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic        w_f7_base;
  logic        w_f7_alt;
  logic [31:0] w_shamt;
  logic        w_legal;
  logic        w_use1;
  logic        w_use2;
  assign w_op      = i_instr[6:0];
  assign w_f3      = i_instr[14:12];
  assign w_f7_base = i_instr[31:25] == F7_BASE;
  assign w_f7_alt  = i_instr[31:25] == F7_ALT;
  assign w_shamt   = {27'b0, i_instr[24:20]};
  always_comb begin
    o_ctrl      = ALU_ADD;
    o_in1       = i_rs1_data;
    o_in2       = i_rs2_data;
    o_rd        = i_instr[11:7];
    o_we        = 1'b0;
    o_is_branch = 1'b0;
    o_is_load   = 1'b0;
    o_is_store  = 1'b0;
    w_legal     = 1'b1;
    w_use1      = 1'b0;
    w_use2      = 1'b0;
    case (w_op)
      OP_R: begin
        w_use1 = 1'b1;
        w_use2 = 1'b1;
        o_we   = 1'b1;
        case (w_f3)
          F3_ADD: begin
            o_ctrl  = w_f7_alt ? ALU_SUB : ALU_ADD;
            w_legal = w_f7_base | w_f7_alt;
          end
          F3_SLL: begin
            o_ctrl  = ALU_SLL;
            w_legal = w_f7_base;
          end
          F3_SLT, F3_SLTU: begin
            o_ctrl  = ALU_SLT;
            w_legal = w_f7_base;
          end
          F3_XOR: begin
            o_ctrl  = ALU_XOR;
            w_legal = w_f7_base;
          end
          F3_SR: begin
            o_ctrl  = w_f7_alt ? ALU_SRA : ALU_SRL;
            w_legal = w_f7_base | w_f7_alt;
          end
          F3_OR: begin
            o_ctrl  = ALU_OR;
            w_legal = w_f7_base;
          end
          default: begin
            o_ctrl  = ALU_AND;
            w_legal = w_f7_base;
          end
        endcase
      end
      OP_IMM: begin
        w_use1 = 1'b1;
        o_we   = 1'b1;
        o_in2  = sext12(i_instr[31:20]);
        case (w_f3)
          F3_ADD: o_ctrl = ALU_ADD;
          F3_SLL: begin
            o_ctrl  = ALU_SLL;
            o_in2   = w_shamt;
            w_legal = w_f7_base;
          end
          F3_SLT, F3_SLTU: o_ctrl = ALU_SLT;
          F3_XOR: o_ctrl = ALU_XOR;
          F3_SR: begin
            o_ctrl  = w_f7_alt ? ALU_SRA : ALU_SRL;
            o_in2   = w_shamt;
            w_legal = w_f7_base | w_f7_alt;
          end
          F3_OR: o_ctrl = ALU_OR;
          default: o_ctrl = ALU_AND;
        endcase
      end
      OP_BR: begin
        w_use1      = 1'b1;
        w_use2      = 1'b1;
        o_is_branch = 1'b1;
        o_rd        = 5'd0;
        case (w_f3)
          F3_BEQ: o_ctrl = ALU_BEQ;
          F3_BNE: o_ctrl = ALU_BNE;
          F3_BLT, F3_BLTU: o_ctrl = ALU_BLT;
          F3_BGE, F3_BGEU: o_ctrl = ALU_BGE;
          default: w_legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        w_use1    = 1'b1;
        o_we      = 1'b1;
        o_is_load = 1'b1;
        o_in2     = sext12(i_instr[31:20]);
        w_legal   = w_f3 != 3'd3 && w_f3 < 3'd6;
      end
      OP_STORE: begin
        w_use1     = 1'b1;
        w_use2     = 1'b1;
        o_is_store = 1'b1;
        o_rd       = 5'd0;
        o_in2      = sext12({i_instr[31:25], i_instr[11:7]});
        w_legal    = w_f3 < 3'd3;
      end
      OP_LUI: begin
        o_we  = 1'b1;
        o_in1 = '0;
        o_in2 = {i_instr[31:12], 12'b0};
      end
      OP_AUIPC: begin
        o_we   = 1'b1;
        o_ctrl = ALU_AUIPC;
        o_in1  = '0;
        o_in2  = {12'b0, i_instr[31:12]};
      end
      default: w_legal = 1'b0;
    endcase
    if (!w_legal) begin
      o_ctrl      = ALU_ADD;
      o_in1       = '0;
      o_in2       = '0;
      o_rd        = 5'd0;
      o_we        = 1'b0;
      o_is_branch = 1'b0;
      o_is_load   = 1'b0;
      o_is_store  = 1'b0;
      w_use1      = 1'b0;
      w_use2      = 1'b0;
    end
  end
  assign o_illegal = !w_legal;
  assign o_rs1     = w_use1 ? i_instr[19:15] : 5'd0;
  assign o_rs2     = w_use2 ? i_instr[24:20] : 5'd0;
endmodule

// File: rtl/alu_issue.sv
// alu_issue: ID/EX issue register with load-use hazard bubble, stall hold and branch flush
module alu_issue
  import alu_issue_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_pc,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic        ex_stall,
  input  logic        ex_branch_taken,
  output logic        id_ready,
  output logic        ex_valid,
  output logic [3:0]  ex_ctrl,
  output logic [31:0] ex_in1,
  output logic [31:0] ex_in2,
  output logic [31:0] ex_pc,
  output logic [4:0]  ex_rd,
  output logic        ex_we,
  output logic        ex_is_branch,
  output logic        ex_is_load,
  output logic        ex_is_store,
  output logic        ex_illegal
);
  ex_reg_t     r_ex;
  ex_reg_t     w_next;
  logic [3:0]  w_ctrl;
  logic [31:0] w_in1;
  logic [31:0] w_in2;
  logic [4:0]  w_rd;
  logic [4:0]  w_rs1;
  logic [4:0]  w_rs2;
  logic        w_we;
  logic        w_br;
  logic        w_ld;
  logic        w_st;
  logic        w_ill;
  logic        w_hazard;
  logic        w_clear;
  logic        w_load;
  alu_decode u_dec (
    .i_instr    (id_instr),
    .i_rs1_data (rs1_data),
    .i_rs2_data (rs2_data),
    .o_ctrl     (w_ctrl),
    .o_in1      (w_in1),
    .o_in2      (w_in2),
    .o_rd       (w_rd),
    .o_rs1      (w_rs1),
    .o_rs2      (w_rs2),
    .o_we       (w_we),
    .o_is_branch(w_br),
    .o_is_load  (w_ld),
    .o_is_store (w_st),
    .o_illegal  (w_ill)
  );
  // unused source fields decode to x0, which can never match a nonzero ex_rd
  assign w_hazard = id_valid & r_ex.valid & r_ex.is_load & (r_ex.rd != 5'd0) &
                    ((r_ex.rd == w_rs1) | (r_ex.rd == w_rs2));
  assign id_ready = (!ex_stall & !w_hazard) | ex_branch_taken;
  assign w_clear  = ex_branch_taken | (!ex_stall & (!id_valid | w_hazard));
  assign w_load   = !ex_branch_taken & !ex_stall & id_valid & !w_hazard;
  assign w_next   = '{valid: 1'b1, ctrl: w_ctrl, in1: w_in1, in2: w_in2, pc: id_pc, rd: w_rd,
                      we: w_we, is_branch: w_br, is_load: w_ld, is_store: w_st, illegal: w_ill};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex <= '0;
    end else if (w_clear) begin
      r_ex.valid     <= 1'b0;
      r_ex.we        <= 1'b0;
      r_ex.is_branch <= 1'b0;
      r_ex.is_load   <= 1'b0;
      r_ex.is_store  <= 1'b0;
      r_ex.illegal   <= 1'b0;
    end else if (w_load) begin
      r_ex <= w_next;
    end
  end
  assign ex_valid     = r_ex.valid;
  assign ex_ctrl      = r_ex.ctrl;
  assign ex_in1       = r_ex.in1;
  assign ex_in2       = r_ex.in2;
  assign ex_pc        = r_ex.pc;
  assign ex_rd        = r_ex.rd;
  assign ex_we        = r_ex.we;
  assign ex_is_branch = r_ex.is_branch;
  assign ex_is_load   = r_ex.is_load;
  assign ex_is_store  = r_ex.is_store;
  assign ex_illegal   = r_ex.illegal;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed vectors with a queue scoreboard checking the ID/EX register each cycle
module tb_alu_issue;
  typedef struct packed {
    logic        f;
    logic        v;
    logic [3:0]  c;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we;
    logic        br;
    logic        ld;
    logic        st;
    logic        ill;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_instr = '0;
  logic [31:0] id_pc = '0;
  logic [31:0] rs1_data = '0;
  logic [31:0] rs2_data = '0;
  logic        ex_stall = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic        id_ready;
  logic        ex_valid;
  logic [3:0]  ex_ctrl;
  logic [31:0] ex_in1;
  logic [31:0] ex_in2;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rd;
  logic        ex_we;
  logic        ex_is_branch;
  logic        ex_is_load;
  logic        ex_is_store;
  logic        ex_illegal;
  exp_t        q[$];
  string       qn[$];
  exp_t        last;
  exp_t        mon_e;
  exp_t        mon_a;
  string       mon_n;
  logic        mon_ok;
  int          checks = 0;
  int          failures = 0;
  exp_t        bub;
  exp_t        zero;
  alu_issue dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .ex_stall(ex_stall),
    .ex_branch_taken(ex_branch_taken), .id_ready(id_ready), .ex_valid(ex_valid),
    .ex_ctrl(ex_ctrl), .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_pc(ex_pc), .ex_rd(ex_rd),
    .ex_we(ex_we), .ex_is_branch(ex_is_branch), .ex_is_load(ex_is_load),
    .ex_is_store(ex_is_store), .ex_illegal(ex_illegal)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input logic [3:0] c, input logic [31:0] a, b, pc,
                              input logic [4:0] rd, input logic we, br, ld, st, ill);
    exp_t e;
    e = '0;
    e.v = 1'b1; e.c = c; e.a = a; e.b = b; e.pc = pc; e.rd = rd;
    e.we = we; e.br = br; e.ld = ld; e.st = st; e.ill = ill;
    return e;
  endfunction
  task automatic step(input logic r, v, input logic [31:0] ins, pc, a, b,
                      input logic stl, bt, input int rdy, input exp_t e, input string nm);
    @(negedge clk);
    rst = r; id_valid = v; id_instr = ins; id_pc = pc; rs1_data = a; rs2_data = b;
    ex_stall = stl; ex_branch_taken = bt;
    #1;
    if (rdy >= 0) begin
      checks++;
      if (id_ready !== rdy[0]) begin
        failures++;
        $display("FAIL %s id_ready got %0b want %0d", nm, id_ready, rdy);
      end
    end
    q.push_back(e);
    qn.push_back(nm);
    last = e;
  endtask
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        mon_n = qn.pop_front();
        mon_a = {1'b0, ex_valid, ex_ctrl, ex_in1, ex_in2, ex_pc, ex_rd,
                 ex_we, ex_is_branch, ex_is_load, ex_is_store, ex_illegal};
        mon_ok = (mon_e.f | mon_e.v) ? (mon_a[109:0] === mon_e[109:0]) :
                 ({mon_a.v, mon_a.we, mon_a.br, mon_a.ld, mon_a.st, mon_a.ill} ===
                  {mon_e.v, mon_e.we, mon_e.br, mon_e.ld, mon_e.st, mon_e.ill});
        checks++;
        if (!mon_ok) begin
          failures++;
          $display("FAIL %s ex got %h want %h", mon_n, mon_a[109:0], mon_e[109:0]);
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    bub = '0;
    zero = '0;
    zero.f = 1'b1;
    step(1, 1, 32'hFFB10093, 32'h0, 32'd10, 32'd0, 0, 0, -1, zero, "reset");
    step(0, 1, 32'hFFB10093, 32'h1, 32'd10, 32'd0, 0, 0, 1,
         mk(4'h0, 32'd10, 32'hFFFFFFFB, 32'h1, 5'd1, 1, 0, 0, 0, 0), "addi");
    step(0, 1, 32'h00022183, 32'h2, 32'h40, 32'd0, 0, 0, 1,
         mk(4'h0, 32'h40, 32'd0, 32'h2, 5'd3, 1, 0, 1, 0, 0), "lw_x3");
    step(0, 1, 32'h006182B3, 32'h3, 32'd7, 32'd8, 0, 0, 0, bub, "load_use_bubble");
    step(0, 1, 32'h006182B3, 32'h3, 32'd7, 32'd8, 0, 0, 1,
         mk(4'h0, 32'd7, 32'd8, 32'h3, 5'd5, 1, 0, 0, 0, 0), "add_after_bubble");
    for (int i = 0; i < 3; i++)
      step(0, 1, 32'h40B504B3, 32'h4, 32'd20, 32'd3, 1, 0, 0, last, "stall_hold");
    step(0, 1, 32'h40B504B3, 32'h4, 32'd20, 32'd3, 0, 0, 1,
         mk(4'h1, 32'd20, 32'd3, 32'h4, 5'd9, 1, 0, 0, 0, 0), "sub");
    step(0, 1, 32'h00208063, 32'h5, 32'd1, 32'd2, 1, 1, 1, bub, "flush_with_stall");
    step(0, 1, 32'h00208063, 32'h6, 32'd1, 32'd2, 0, 0, 1,
         mk(4'h7, 32'd1, 32'd2, 32'h6, 5'd0, 0, 1, 0, 0, 0), "beq");
    step(0, 1, 32'h0020D063, 32'h7, 32'd5, 32'd6, 0, 0, 1,
         mk(4'hD, 32'd5, 32'd6, 32'h7, 5'd0, 0, 1, 0, 0, 0), "bge");
    step(0, 1, 32'h12345397, 32'h100, 32'hDEAD, 32'hBEEF, 0, 0, 1,
         mk(4'hB, 32'd0, 32'h00012345, 32'h100, 5'd7, 1, 0, 0, 0, 0), "auipc");
    step(0, 1, 32'hABCDE437, 32'h101, 32'h1, 32'h2, 0, 0, 1,
         mk(4'h0, 32'd0, 32'hABCDE000, 32'h101, 5'd8, 1, 0, 0, 0, 0), "lui");
    step(0, 1, 32'h40315093, 32'h102, 32'h80000000, 32'h0, 0, 0, 1,
         mk(4'hA, 32'h80000000, 32'd3, 32'h102, 5'd1, 1, 0, 0, 0, 0), "srai");
    step(0, 1, 32'h00532423, 32'h103, 32'h200, 32'h55, 0, 0, 1,
         mk(4'h0, 32'h200, 32'd8, 32'h103, 5'd0, 0, 0, 0, 1, 0), "sw_pos");
    step(0, 1, 32'hFE532E23, 32'h104, 32'h200, 32'h55, 0, 0, 1,
         mk(4'h0, 32'h200, 32'hFFFFFFFC, 32'h104, 5'd0, 0, 0, 0, 1, 0), "sw_neg");
    step(0, 1, 32'h0000007F, 32'h105, 32'h11, 32'h22, 0, 0, 1,
         mk(4'h0, 32'd0, 32'd0, 32'h105, 5'd0, 0, 0, 0, 0, 1), "illegal_7f");
    step(0, 1, 32'h0000006F, 32'h106, 32'h11, 32'h22, 0, 0, 1,
         mk(4'h0, 32'd0, 32'd0, 32'h106, 5'd0, 0, 0, 0, 0, 1), "illegal_jal");
    step(0, 0, 32'h006182B3, 32'h0, 32'h0, 32'h0, 0, 0, 1, bub, "idle_bubble");
    step(0, 1, 32'h00022003, 32'h107, 32'h10, 32'h0, 0, 0, 1,
         mk(4'h0, 32'h10, 32'd0, 32'h107, 5'd0, 1, 0, 1, 0, 0), "lw_x0");
    step(0, 1, 32'h006002B3, 32'h108, 32'h0, 32'd9, 0, 0, 1,
         mk(4'h0, 32'd0, 32'd9, 32'h108, 5'd5, 1, 0, 0, 0, 0), "x0_no_hazard");
    step(0, 1, 32'h00022183, 32'h109, 32'h44, 32'h0, 0, 0, 1,
         mk(4'h0, 32'h44, 32'd0, 32'h109, 5'd3, 1, 0, 1, 0, 0), "lw_x3_again");
    step(0, 1, 32'h00322023, 32'h10A, 32'h30, 32'h9, 0, 0, 0, bub, "rs2_hazard");
    step(0, 1, 32'h00322023, 32'h10A, 32'h30, 32'h9, 0, 0, 1,
         mk(4'h0, 32'h30, 32'd0, 32'h10A, 5'd0, 0, 0, 0, 1, 0), "sw_after_bubble");
    step(0, 1, 32'h00022183, 32'h10B, 32'h48, 32'h0, 0, 0, 1,
         mk(4'h0, 32'h48, 32'd0, 32'h10B, 5'd3, 1, 0, 1, 0, 0), "lw_x3_flush");
    step(0, 1, 32'h006182B3, 32'h10C, 32'd1, 32'd2, 0, 1, 1, bub, "flush_over_hazard");
    step(0, 1, 32'h006182B3, 32'h10C, 32'd1, 32'd2, 0, 0, 1,
         mk(4'h0, 32'd1, 32'd2, 32'h10C, 5'd5, 1, 0, 0, 0, 0), "add_after_flush");
    step(1, 1, 32'h003130B3, 32'h10D, 32'd4, 32'd5, 1, 1, -1, zero, "reset_midstream");
    step(0, 1, 32'h003130B3, 32'h10E, 32'd4, 32'd5, 0, 0, 1,
         mk(4'h9, 32'd4, 32'd5, 32'h10E, 5'd1, 1, 0, 0, 0, 0), "sltu");
    step(0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0, 0, 1, bub, "final_idle");
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain queue got %0d want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
